// File: rtl/dpsk_mod_pkg.sv
// Shared dpsk path constants and FSM state type; the cosine generator uses the same values.
package dpsk_mod_pkg;

    localparam int unsigned DATA_W            = 8;
    localparam int unsigned SAMPLES_PER_CYCLE = 20;
    localparam int unsigned MID_LEVEL         = 128;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/dpsk_mod_if.sv
// Serial bit stream handshake feeding the dpsk modulator.
interface dpsk_mod_if;

    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (output bit_in, output bit_valid, input bit_ready);
    modport slave  (input bit_in, input bit_valid, output bit_ready);

endinterface

// File: rtl/dpsk_mod_diff_encoder.sv
// Differential reference register: loads ref ^ bit_in on each accepted bit.
module dpsk_mod_diff_encoder (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic bit_in,
    output logic ref_bit
);

    logic enc_c;

    assign enc_c = ref_bit ^ bit_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ref_bit <= 1'b0;
        end else if (load) begin
            ref_bit <= enc_c;
        end
    end

endmodule

// File: rtl/dpsk_mod.sv
// DPSK modulator: passes or inverts the carrier according to the differentially encoded bit.
module dpsk_mod
    import dpsk_mod_pkg::*;
#(
    parameter int unsigned CYCLES_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    dpsk_mod_if.slave         bs,
    input  logic [DATA_W-1:0] carrier_in,
    output logic [DATA_W-1:0] mod_out,
    output logic              mod_valid,
    output logic              enc_bit,
    output logic              underrun
);

    localparam int unsigned SPB   = SAMPLES_PER_CYCLE * CYCLES_PER_BIT;
    localparam int unsigned CNT_W = $clog2(SPB);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPB - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  sample_cnt, sample_cnt_d;
    logic [DATA_W-1:0] mod_out_d;
    logic              mod_valid_d;
    logic              underrun_d;
    logic              at_last;
    logic              accept;

    assign at_last      = (sample_cnt == LAST_CNT);
    assign bs.bit_ready = rst & ((state == IDLE) | ((state == RUN) & at_last));
    assign accept       = bs.bit_valid & bs.bit_ready;

    dpsk_mod_diff_encoder u_diff_encoder (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .bit_in  (bs.bit_in),
        .ref_bit (enc_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            mod_out    <= DATA_W'(MID_LEVEL);
            mod_valid  <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_d;
            sample_cnt <= sample_cnt_d;
            mod_out    <= mod_out_d;
            mod_valid  <= mod_valid_d;
            underrun   <= underrun_d;
        end
    end

    // Boundary-crossing sample still uses the old enc_bit; the new one applies from the next cycle.
    always_comb begin
        state_d      = state;
        sample_cnt_d = sample_cnt;
        mod_out_d    = mod_out;
        mod_valid_d  = mod_valid;
        underrun_d   = 1'b0;
        case (state)
            IDLE: begin
                mod_out_d   = DATA_W'(MID_LEVEL);
                mod_valid_d = 1'b0;
                if (accept) begin
                    state_d      = RUN;
                    sample_cnt_d = '0;
                end
            end
            RUN: begin
                mod_out_d   = enc_bit ? ~carrier_in : carrier_in;
                mod_valid_d = 1'b1;
                if (!at_last) begin
                    sample_cnt_d = sample_cnt + CNT_W'(1);
                end else if (accept) begin
                    sample_cnt_d = '0;
                end else begin
                    state_d      = IDLE;
                    sample_cnt_d = '0;
                    underrun_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dpsk_mod.sv
// Scoreboard bench for dpsk_mod with one carrier period per bit (SPB = 20).
module tb_dpsk_mod;

    localparam int SPB = 20;

    logic       clk;
    logic       rst;
    logic [7:0] carrier_in;
    logic [7:0] mod_out;
    logic       mod_valid;
    logic       enc_bit;
    logic       underrun;

    dpsk_mod_if bs ();

    dpsk_mod #(.CYCLES_PER_BIT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .bs         (bs),
        .carrier_in (carrier_in),
        .mod_out    (mod_out),
        .mod_valid  (mod_valid),
        .enc_bit    (enc_bit),
        .underrun   (underrun)
    );

    logic [7:0] exp_q[$];
    logic       enc_log[$];
    logic [7:0] tbl [3] = '{8'd255, 8'd250, 8'd128};
    int         vectors = 0;
    int         miscompares = 0;
    int         und_cnt = 0;
    int         und_exp = 0;
    int         samples = 0;
    logic       enc_m = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: every valid sample is matched against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (mod_valid === 1'b1) begin
            logic [7:0] e;
            samples++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL extra_sample: got mod_out=%0d, expected no valid sample", mod_out);
            end else begin
                e = exp_q.pop_front();
                if (mod_out !== e) begin
                    miscompares++;
                    $display("FAIL mod_out: got %0d, expected %0d", mod_out, e);
                end
            end
        end
        if (underrun === 1'b1) und_cnt++;
    end

    task automatic send_bits(input logic [7:0] bits, input int n);
        logic [7:0] c;
        int j;
        @(negedge clk);
        bs.bit_in = bits[0];
        bs.bit_valid = 1'b1;
        vectors++;
        if (bs.bit_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_ready: got %b, expected 1", bs.bit_ready);
        end
        enc_m = enc_m ^ bits[0];
        for (int k = 0; k < n * SPB; k++) begin
            @(negedge clk);
            j = k / SPB;
            if (k % SPB == 0) begin
                enc_log.push_back(enc_bit);
                vectors++;
                if (enc_bit !== enc_m) begin
                    miscompares++;
                    $display("FAIL enc_bit: bit %0d got %b, expected %b", j, enc_bit, enc_m);
                end
                bs.bit_valid = (j < n - 1);
                bs.bit_in    = (j < n - 1) ? bits[j + 1] : 1'b0;
            end
            vectors++;
            if (bs.bit_ready !== (k % SPB == SPB - 1)) begin
                miscompares++;
                $display("FAIL run_ready: k=%0d got %b, expected %b", k, bs.bit_ready, (k % SPB == SPB - 1));
            end
            c = (k % SPB < 3) ? tbl[k % SPB] : 8'($urandom_range(0, 255));
            carrier_in = c;
            exp_q.push_back(enc_m ? (8'd255 - c) : c);
            if ((k % SPB == SPB - 1) && (j < n - 1)) enc_m = enc_m ^ bits[j + 1];
        end
        @(negedge clk);
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL underrun_pulse: got %b, expected 1", underrun);
        end
        und_exp++;
        @(negedge clk);
        vectors++;
        if (underrun !== 1'b0 || mod_valid !== 1'b0 || mod_out !== 8'd128) begin
            miscompares++;
            $display("FAIL post_underrun: got und=%b valid=%b out=%0d, expected 0 0 128",
                     underrun, mod_valid, mod_out);
        end
        vectors++;
        if (und_cnt !== und_exp || exp_q.size() != 0 || enc_bit !== enc_m) begin
            miscompares++;
            $display("FAIL bit_end: got und_cnt=%0d left=%0d enc=%b, expected %0d 0 %b",
                     und_cnt, exp_q.size(), enc_bit, und_exp, enc_m);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if (mod_out !== 8'd128 || mod_valid !== 1'b0 || bs.bit_ready !== 1'b0 ||
            enc_bit !== 1'b0 || underrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%0d valid=%b ready=%b enc=%b und=%b, expected 128 0 0 0 0",
                     mod_out, mod_valid, bs.bit_ready, enc_bit, underrun);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bs.bit_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_release: got %b, expected 1", bs.bit_ready);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (mod_valid !== 1'b0 || mod_out !== 8'd128 || und_cnt !== 0) begin
            miscompares++;
            $display("FAIL idle_hold: got valid=%b out=%0d und_cnt=%0d, expected 0 128 0",
                     mod_valid, mod_out, und_cnt);
        end
    endtask

    task automatic test_single_bit();
        samples = 0;
        enc_log.delete();
        send_bits(8'b0, 1);
        vectors++;
        if (samples !== SPB || enc_log[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL single_bit: got samples=%0d enc=%b, expected %0d 0", samples, enc_log[0], SPB);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_seq [3] = '{1'b1, 1'b0, 1'b0};
        samples = 0;
        enc_log.delete();
        send_bits(8'b0000_0011, 3);
        vectors++;
        if (samples !== 3 * SPB) begin
            miscompares++;
            $display("FAIL b2b_samples: got %0d, expected %0d", samples, 3 * SPB);
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (enc_log[i] !== exp_seq[i]) begin
                miscompares++;
                $display("FAIL b2b_enc: bit %0d got %b, expected %b", i, enc_log[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_underrun();
        enc_log.delete();
        send_bits(8'b1, 1);
        repeat (4) @(negedge clk);
        send_bits(8'b1, 1);
        vectors++;
        if (enc_log[0] !== 1'b1 || enc_log[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL ref_retained: got %b%b, expected 10", enc_log[0], enc_log[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c;
        @(negedge clk);
        bs.bit_in = 1'b1;
        bs.bit_valid = 1'b1;
        enc_m = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (k == 0) bs.bit_valid = 1'b0;
            c = 8'($urandom_range(0, 255));
            carrier_in = c;
            exp_q.push_back(8'd255 - c);
        end
        @(negedge clk);
        vectors++;
        if (mod_valid !== 1'b1 || enc_bit !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset: got valid=%b enc=%b, expected 1 1", mod_valid, enc_bit);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (mod_out !== 8'd128 || mod_valid !== 1'b0 || enc_bit !== 1'b0 ||
            bs.bit_ready !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL async_reset: got out=%0d valid=%b enc=%b ready=%b left=%0d, expected 128 0 0 0 0",
                     mod_out, mod_valid, enc_bit, bs.bit_ready, exp_q.size());
        end
        enc_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        enc_log.delete();
        send_bits(8'b0, 1);
        vectors++;
        if (enc_log[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_enc: got %b, expected 0", enc_log[0]);
        end
    endtask

    initial begin
        rst = 1'b0;
        bs.bit_in = 1'b0;
        bs.bit_valid = 1'b0;
        carrier_in = 8'd0;
        test_reset();
        test_single_bit();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
